// File: rtl/iteration_frame_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : iteration_frame_packer_if
// Description : Byte stream from the frame packer to the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface iteration_frame_packer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/iteration_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : iteration_frame_packer
// Description : Captures identifier results and serializes them as a byte
//               frame; optional timestamp bytes via FRAME_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module iteration_frame_packer #(
    parameter logic [7:0] SYNC_BYTE        = 8'hA5,
    parameter int         FRAME_GAP_CYCLES = 72,
    parameter int         TX_TIMEOUT_TICKS = 72000
) (
    input  wire         clk_72MHz,
    input  wire         reset_n,
    input  wire         identifier_ready,
    input  wire  [16:0] polynomial,
    input  wire  [16:0] iteration_0,
    input  wire  [16:0] iteration_1,
    input  wire  [16:0] iteration_2,
    input  wire  [16:0] iteration_3,
    input  wire  [16:0] iteration_4,
    input  wire  [16:0] iteration_5,
    input  wire  [16:0] iteration_6,
    input  wire  [16:0] iteration_7,
    input  wire  [23:0] sys_ts,
    output logic        identifier_reset,
    iteration_frame_packer_if.master tx,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count
);

`ifdef FRAME_TIMESTAMP_EN
    localparam int c_TS_BYTES = 3;
`else
    localparam int c_TS_BYTES = 0;
`endif
    localparam int c_FRAME_LEN = 30 + c_TS_BYTES;
    localparam int c_ITER_BASE = 5 + c_TS_BYTES;
    localparam int c_STALL_W   = $clog2(TX_TIMEOUT_TICKS + 1);
    localparam int c_GAP_W     = $clog2(FRAME_GAP_CYCLES + 1);

    localparam logic [5:0]           c_LAST_IDX    = 6'(c_FRAME_LEN - 1);
    localparam logic [c_STALL_W-1:0] c_STALL_LIMIT = c_STALL_W'(TX_TIMEOUT_TICKS - 1);
    localparam logic [c_GAP_W-1:0]   c_GAP_LIMIT   = c_GAP_W'(FRAME_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_armed;
    logic [16:0]            r_poly;
    logic [16:0]            r_iter [0:7];
    logic [5:0]             r_byte_idx;
    logic [7:0]             r_tx_data;
    logic                   r_tx_valid;
    logic [7:0]             r_csum;
    logic [c_STALL_W-1:0]   r_stall_cnt;
    logic [c_GAP_W-1:0]     r_gap_cnt;

    logic [16:0]            w_iter_in [0:7];
    logic [7:0]             w_frame [0:c_FRAME_LEN-1];
    logic [7:0]             w_flags;
    logic [7:0]             w_csum_next;
    logic [5:0]             w_next_idx;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_last_accept;
    logic                   w_stall;
    logic                   w_abort;

`ifdef FRAME_TIMESTAMP_EN
    logic [23:0]            r_ts;
`else
    logic                   w_unused_ts;
    assign w_unused_ts = ^sys_ts;
`endif

    assign w_iter_in[0] = iteration_0;
    assign w_iter_in[1] = iteration_1;
    assign w_iter_in[2] = iteration_2;
    assign w_iter_in[3] = iteration_3;
    assign w_iter_in[4] = iteration_4;
    assign w_iter_in[5] = iteration_5;
    assign w_iter_in[6] = iteration_6;
    assign w_iter_in[7] = iteration_7;

    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign busy        = (r_state != S_IDLE);

    // The sync byte is excluded; the byte now on the bus folds in as it is accepted.
    assign w_csum_next = r_csum ^ ((r_byte_idx != 6'd0) ? r_tx_data : 8'h00);
    assign w_next_idx  = r_byte_idx + 6'd1;

    always_comb begin
        w_flags = '0;
        for (int i = 0; i < c_FRAME_LEN; i++) begin
            w_frame[i] = '0;
        end
        for (int k = 0; k < 8; k++) begin
            w_flags[k] = |r_iter[k];
        end
        w_frame[0] = SYNC_BYTE;
        w_frame[1] = w_flags;
        w_frame[2] = {7'd0, r_poly[16]};
        w_frame[3] = r_poly[15:8];
        w_frame[4] = r_poly[7:0];
`ifdef FRAME_TIMESTAMP_EN
        w_frame[5] = r_ts[23:16];
        w_frame[6] = r_ts[15:8];
        w_frame[7] = r_ts[7:0];
`endif
        for (int k = 0; k < 8; k++) begin
            w_frame[c_ITER_BASE + 3*k]     = {7'd0, r_iter[k][16]};
            w_frame[c_ITER_BASE + 3*k + 1] = r_iter[k][15:8];
            w_frame[c_ITER_BASE + 3*k + 2] = r_iter[k][7:0];
        end
        w_frame[c_FRAME_LEN-1] = w_csum_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_capture     = 1'b0;
        w_accept      = 1'b0;
        w_last_accept = 1'b0;
        w_abort       = 1'b0;
        w_stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (identifier_ready && r_armed) begin
                    w_capture    = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                w_accept = r_tx_valid && tx.tx_ready;
                w_stall  = r_tx_valid && !tx.tx_ready;
                if (w_accept && (r_byte_idx == c_LAST_IDX)) begin
                    w_last_accept = 1'b1;
                    w_state_next  = S_GAP;
                end else if (w_stall && (r_stall_cnt == c_STALL_LIMIT)) begin
                    w_abort      = 1'b1;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LIMIT) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_armed          <= 1'b1;
            r_poly           <= '0;
            for (int k = 0; k < 8; k++) begin
                r_iter[k] <= '0;
            end
`ifdef FRAME_TIMESTAMP_EN
            r_ts             <= '0;
`endif
            r_byte_idx       <= '0;
            r_tx_data        <= '0;
            r_tx_valid       <= 1'b0;
            r_csum           <= '0;
            r_stall_cnt      <= '0;
            r_gap_cnt        <= '0;
            identifier_reset <= 1'b0;
            frame_count      <= '0;
            drop_count       <= '0;
        end else begin
            identifier_reset <= 1'b0;
            // Re-arming only on a low ready keeps a held result from being taken twice.
            if (!identifier_ready) begin
                r_armed <= 1'b1;
            end
            if (w_capture) begin
                r_armed          <= 1'b0;
                r_poly           <= polynomial;
                for (int k = 0; k < 8; k++) begin
                    r_iter[k] <= w_iter_in[k];
                end
`ifdef FRAME_TIMESTAMP_EN
                r_ts             <= sys_ts;
`endif
                identifier_reset <= 1'b1;
                r_tx_data        <= SYNC_BYTE;
                r_tx_valid       <= 1'b1;
                r_byte_idx       <= '0;
                r_csum           <= '0;
                r_stall_cnt      <= '0;
            end
            if (w_accept) begin
                r_stall_cnt <= '0;
                r_csum      <= w_csum_next;
                if (w_last_accept) begin
                    r_tx_valid  <= 1'b0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    r_byte_idx <= w_next_idx;
                    r_tx_data  <= w_frame[w_next_idx];
                end
            end else if (w_stall) begin
                if (w_abort) begin
                    r_tx_valid  <= 1'b0;
                    r_stall_cnt <= '0;
                    if (drop_count != 8'hFF) begin
                        drop_count <= drop_count + 8'd1;
                    end
                end else begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iteration_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iteration_frame_packer
// Description : Directed, table-driven bench for iteration_frame_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iteration_frame_packer;

    localparam int GAP = 8;
    localparam int TMO = 40;
    localparam logic [23:0] TS_VAL = 24'h123456;
`ifdef FRAME_TIMESTAMP_EN
    localparam logic [7:0] TS_X = 8'h70;  // 12 ^ 34 ^ 56
`else
    localparam logic [7:0] TS_X = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        identifier_ready = 1'b0;
    logic [16:0] polynomial = '0;
    logic [16:0] it_in [0:7];
    logic [23:0] sys_ts = '0;
    logic        identifier_reset;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  drop_count;

    iteration_frame_packer_if u_if();

    iteration_frame_packer #(
        .SYNC_BYTE        (8'hA5),
        .FRAME_GAP_CYCLES (GAP),
        .TX_TIMEOUT_TICKS (TMO)
    ) dut (
        .clk_72MHz        (clk),
        .reset_n          (reset_n),
        .identifier_ready (identifier_ready),
        .polynomial       (polynomial),
        .iteration_0      (it_in[0]),
        .iteration_1      (it_in[1]),
        .iteration_2      (it_in[2]),
        .iteration_3      (it_in[3]),
        .iteration_4      (it_in[4]),
        .iteration_5      (it_in[5]),
        .iteration_6      (it_in[6]),
        .iteration_7      (it_in[7]),
        .sys_ts           (sys_ts),
        .identifier_reset (identifier_reset),
        .tx               (u_if),
        .busy             (busy),
        .frame_count      (frame_count),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0]      poly;
        logic [7:0][16:0] it;
        logic [7:0]       flags;
        logic [7:0]       csum;
        int               mode;
    } vec_t;

    vec_t       vecs [5];
    int         checks = 0;
    int         errors = 0;
    int         exp_frames = 0;
    int         exp_drops = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push3(input logic [23:0] f);
        exp_q.push_back(f[23:16]);
        exp_q.push_back(f[15:8]);
        exp_q.push_back(f[7:0]);
    endfunction

    function automatic void build_frame(input int v);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(vecs[v].flags);
        push3({7'd0, vecs[v].poly});
`ifdef FRAME_TIMESTAMP_EN
        push3(TS_VAL);
`endif
        for (int i = 0; i < 8; i++) push3({7'd0, vecs[v].it[i]});
        exp_q.push_back(vecs[v].csum ^ TS_X);
    endfunction

    // mode 0: always ready, 1: ready 1,0,0 pattern, 2: stall after 3 bytes, 3: reset at byte 12
    task automatic run_frame(input int v, input int mode);
        int         nb, cyc, stall, gap, flen;
        logic       done, rdy, prev_stall;
        logic [7:0] prev_data;
        nb = 0; cyc = 0; stall = 0; gap = 0;
        done = 1'b0; rdy = 1'b0; prev_stall = 1'b0; prev_data = '0;
        build_frame(v);
        flen = exp_q.size();
        polynomial = vecs[v].poly;
        for (int i = 0; i < 8; i++) it_in[i] = vecs[v].it[i];
        sys_ts = TS_VAL;
        u_if.tx_ready = 1'b0;
        identifier_ready = 1'b1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("ack_pulse", identifier_reset, 1);
                chk("first_valid", u_if.tx_valid, 1);
                identifier_ready = 1'b0;
                polynomial = 17'h1FFFF;
                for (int i = 0; i < 8; i++) it_in[i] = 17'h1FFFF;
                sys_ts = 24'hFFFFFF;
            end
            if (cyc == 2) chk("ack_width", identifier_reset, 0);
            if (mode == 2 && cyc > 1 && !u_if.tx_valid) begin
                done = 1'b1;
            end else if (mode == 3 && nb == 12) begin
                #2 reset_n = 1'b0;
                #1;
                chk("arst_valid", u_if.tx_valid, 0);
                chk("arst_busy", busy, 0);
                chk("arst_frames", frame_count, 0);
                chk("arst_drops", drop_count, 0);
                exp_frames = 0;
                exp_drops = 0;
                u_if.tx_ready = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                done = 1'b1;
            end else begin
                case (mode)
                    1:       rdy = (cyc % 3 == 1);
                    2:       rdy = (nb < 3);
                    default: rdy = 1'b1;
                endcase
                u_if.tx_ready = rdy;
                if (prev_stall) chk("stable", u_if.tx_data, prev_data);
                if (u_if.tx_valid && rdy) begin
                    chk($sformatf("v%0d_byte%0d", v, nb), u_if.tx_data, exp_q[nb]);
                    nb++;
                    if (nb == flen) done = 1'b1;
                end
                if (u_if.tx_valid && !rdy) stall++;
                prev_stall = u_if.tx_valid && !rdy;
                prev_data  = u_if.tx_data;
            end
        end
        chk("frame_done", done, 1);
        if (mode == 3) return;
        if (mode == 2) begin
            chk("stall_cycles", stall, TMO);
            exp_drops++;
        end else begin
            @(negedge clk);
            exp_frames++;
        end
        chk("end_valid", u_if.tx_valid, 0);
        chk("frame_count", frame_count, exp_frames);
        chk("drop_count", drop_count, exp_drops);
        while (busy && gap < 1000) begin
            gap++;
            @(negedge clk);
        end
        chk("gap_cycles", gap, GAP);
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 8; i++) it_in[i] = '0;
        u_if.tx_ready = 1'b0;

        vecs[0].poly = 17'h00001; vecs[0].it = '0; vecs[0].it[0] = 17'h00010;
        vecs[0].flags = 8'h01; vecs[0].csum = 8'h10; vecs[0].mode = 0;
        vecs[1] = vecs[0]; vecs[1].mode = 1;
        vecs[2].poly = 17'h1FFFF; vecs[2].it = '0;
        vecs[2].flags = 8'h00; vecs[2].csum = 8'h01; vecs[2].mode = 0;
        vecs[3].poly = 17'h12345; vecs[3].it = '0;
        vecs[3].it[3] = 17'h00001; vecs[3].it[7] = 17'h1ABCD;
        vecs[3].flags = 8'h88; vecs[3].csum = 8'h89; vecs[3].mode = 1;
        vecs[4].poly = 17'h00000; vecs[4].it = {8{17'h10000}};
        vecs[4].flags = 8'hFF; vecs[4].csum = 8'hFF; vecs[4].mode = 0;

        #1 reset_n = 1'b0;
        #3;
        chk("rst_valid", u_if.tx_valid, 0);
        chk("rst_data", u_if.tx_data, 0);
        chk("rst_ack", identifier_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frame_count, 0);
        chk("rst_drops", drop_count, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) run_frame(v, vecs[v].mode);

        polynomial = vecs[2].poly;
        for (int i = 0; i < 8; i++) it_in[i] = vecs[2].it[i];
        u_if.tx_ready = 1'b1;
        identifier_ready = 1'b1;
        pulses = 0;
        for (int c = 0; c < 220; c++) begin
            @(negedge clk);
            if (identifier_reset) pulses++;
        end
        chk("held_one_capture", pulses, 1);
        exp_frames++;
        chk("held_frame_count", frame_count, exp_frames);
        identifier_ready = 1'b0;
        @(negedge clk);
        identifier_ready = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (identifier_reset) pulses++;
        end
        chk("rearm_capture", pulses, 1);
        identifier_ready = 1'b0;
        @(negedge clk);
        identifier_ready = 1'b1;
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (identifier_reset) pulses++;
        end
        chk("served_after_gap", pulses, 1);
        identifier_ready = 1'b0;
        repeat (60) @(negedge clk);
        exp_frames += 2;
        chk("held_total_frames", frame_count, exp_frames);
        chk("held_idle", busy, 0);

        run_frame(3, 2);
        run_frame(1, 3);
        @(negedge clk);
        run_frame(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
